ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: AW, 3, address width (8 locations).
REQ-002 Parameter: DW, 16, data width.
REQ-003 Parameter: RD_LAT, 1, clk cycles from ram_re high to ram_dout valid (legal 1..4).
REQ-004 clk  input  1  single clock; all state on rising edge; RAM rdclk and wclk both tied to clk.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req0 / req1  input  1  access request from requester 0 / 1; held high until done.
REQ-007 wr0 / wr1  input  1  1 = write, 0 = read; qualified by req.
REQ-008 addr0 / addr1  input  AW  target address.
REQ-009 wdata0 / wdata1  input  DW  write data.
REQ-010 gnt0 / gnt1  output  1  one-cycle pulse: request accepted, RAM access in progress.
REQ-011 done0 / done1  output  1  one-cycle pulse: access complete.
REQ-012 rdata  output  DW  read data, valid in done cycle of a read, held until next read completes.
REQ-013 ram_we / ram_re  output  1  RAM write/read enables.
REQ-014 ram_waddr / ram_raddr  output  AW  RAM write/read addresses.
REQ-015 ram_din  output  DW  RAM write data.
REQ-016 ram_dout  input  DW  RAM read data.

Function
REQ-017 FSM states IDLE, ACCESS, WAIT, DONE; all outputs registered.
REQ-018 IDLE: no request -> stay; any request -> ACCESS, latching winner id, wr, addr, wdata at that edge.
REQ-019 Arbitration round-robin: single requester wins; both requesting -> the one not served last wins; after reset requester 0 has priority.
REQ-020 ACCESS lasts exactly 1 cycle: gnt of winner high; write -> ram_we=1, ram_waddr/ram_din = latched values; read -> ram_re=1, ram_raddr = latched addr.
REQ-021 ACCESS -> DONE for writes; ACCESS -> WAIT for reads.
REQ-022 WAIT lasts RD_LAT-1 cycles (zero when RD_LAT=1, i.e. ACCESS -> DONE directly); rdata captured from ram_dout on the edge entering DONE.
REQ-023 DONE lasts 1 cycle: done of winner high; -> IDLE unconditionally; last-served pointer updated to winner.
REQ-024 Latency, req high at edge 0: gnt cycle 1; write done cycle 2; read done cycle 2+RD_LAT-1; next grant no earlier than cycle after IDLE.
REQ-025 Requester drops req on the edge at which it samples done=1; req still high in IDLE is treated as a new request.
REQ-026 ram_we and ram_re never high together; never high outside ACCESS.
REQ-027 req deasserted or addr/wdata/wr changed after grant: ignored, latched transaction completes.
REQ-028 Same-address write then read by either requester returns the written data (transactions strictly serialized).
REQ-029 Addresses cover 0..2^AW-1; no wrap or range check needed.
REQ-030 gnt0/gnt1 and done0/done1 are mutually exclusive; at most one of gnt/done high per cycle.

Reset
REQ-031 rst high: FSM -> IDLE immediately, independent of clk.
REQ-032 Reset values: gnt*, done*, ram_we, ram_re = 0; rdata, ram_din, ram_waddr, ram_raddr = 0; pointer = requester 0 priority.
REQ-033 Reset mid-transaction aborts it: no done issued; RAM contents not altered by the controller after rst rises.
REQ-034 After rst falls, first request is sampled on the first rising edge of clk.

Verification
REQ-035 Write/readback: req0 wr addr 3 data 16'hABCD, then req0 read addr 3 -> ram_we one cycle with waddr 3; done0 returns rdata 16'hABCD.
REQ-036 Simultaneous: req0 wr addr 5 16'h1234 and req1 wr addr 5 16'h5678 at same edge -> gnt0 first, then gnt1; read addr 5 returns 16'h5678.
REQ-037 Fairness: both held continuously with reads -> grants alternate 0,1,0,1 over 8 transactions; no starvation.
REQ-038 Latency: RD_LAT=1 read done 2 cycles after req edge; RD_LAT=3 read done 4 cycles after; write always 2.
REQ-039 Reset mid-read: rst asserted during WAIT -> all outputs 0 at once, no done; next req1 read addr 5 completes normally.
REQ-040 Enable exclusivity: random traffic 1000 transactions -> ram_we & ram_re never both 1, scoreboard matches every read.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bus between the two requesters, the single-port-pair RAM and ram_arbiter.
//   slave  : arbiter side (takes requests and RAM read data, drives grants,
//            completions, read data and the RAM control/address/data).
//   master : environment side (requesters plus the RAM model).
interface ram_arbiter_if #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 16
);
    logic          req0;
    logic          req1;
    logic          wr0;
    logic          wr1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          done0;
    logic          done1;
    logic [DW-1:0] rdata;
    logic          ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, ram_dout,
        output gnt0, gnt1, done0, done1, rdata,
               ram_we, ram_re, ram_waddr, ram_raddr, ram_din
    );

    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, ram_dout,
        input  gnt0, gnt1, done0, done1, rdata,
               ram_we, ram_re, ram_waddr, ram_raddr, ram_din
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a RAM with separate read and
// write ports. Transactions are strictly serialized: IDLE -> ACCESS -> [WAIT]
// -> DONE -> IDLE. All outputs are registered.
//   clk, rst   : single clock, asynchronous active-high reset
//   bus.req*/wr*/addr*/wdata*  : requester inputs, held until done
//   bus.gnt*/done*             : one-cycle accept / completion pulses
//   bus.rdata                  : read data, held until the next read completes
//   bus.ram_*                  : RAM enables, addresses and data
// RD_LAT (1..4) is the cycle count from ram_re high to ram_dout valid.
module ram_arbiter #(
    parameter int unsigned AW     = 3,
    parameter int unsigned DW     = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);
    localparam int unsigned CW = 2;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t        state;
    logic          win;      // requester owning the current transaction
    logic          cur_wr;   // current transaction is a write
    logic          last;     // requester served last; reset favours requester 0
    logic [CW-1:0] wcnt;     // remaining WAIT cycles minus one

    logic          sel_c;
    logic          sel_wr_c;
    logic [AW-1:0] sel_addr_c;
    logic [DW-1:0] sel_wdata_c;

    // Round-robin pick and the winner's request fields.
    always_comb begin
        sel_c = bus.req1;
        if (bus.req0 && bus.req1) begin
            sel_c = ~last;
        end
        sel_wr_c    = sel_c ? bus.wr1    : bus.wr0;
        sel_addr_c  = sel_c ? bus.addr1  : bus.addr0;
        sel_wdata_c = sel_c ? bus.wdata1 : bus.wdata0;
    end

    // Transaction FSM with registered pulses and RAM controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            win           <= 1'b0;
            cur_wr        <= 1'b0;
            last          <= 1'b1;
            wcnt          <= '0;
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.done0     <= 1'b0;
            bus.done1     <= 1'b0;
            bus.rdata     <= '0;
            bus.ram_we    <= 1'b0;
            bus.ram_re    <= 1'b0;
            bus.ram_waddr <= '0;
            bus.ram_raddr <= '0;
            bus.ram_din   <= '0;
        end else begin
            bus.gnt0   <= 1'b0;
            bus.gnt1   <= 1'b0;
            bus.done0  <= 1'b0;
            bus.done1  <= 1'b0;
            bus.ram_we <= 1'b0;
            bus.ram_re <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        state    <= ACCESS;
                        win      <= sel_c;
                        cur_wr   <= sel_wr_c;
                        bus.gnt0 <= ~sel_c;
                        bus.gnt1 <= sel_c;
                        if (sel_wr_c) begin
                            bus.ram_we    <= 1'b1;
                            bus.ram_waddr <= sel_addr_c;
                            bus.ram_din   <= sel_wdata_c;
                        end else begin
                            bus.ram_re    <= 1'b1;
                            bus.ram_raddr <= sel_addr_c;
                        end
                    end
                end
                ACCESS: begin
                    // Writes and single-cycle reads skip WAIT entirely.
                    if (cur_wr || RD_LAT == 1) begin
                        state     <= DONE;
                        bus.done0 <= ~win;
                        bus.done1 <= win;
                        if (!cur_wr) begin
                            bus.rdata <= bus.ram_dout;
                        end
                    end else begin
                        state <= WAIT;
                        wcnt  <= CW'(RD_LAT - 2);
                    end
                end
                WAIT: begin
                    if (wcnt == '0) begin
                        state     <= DONE;
                        bus.done0 <= ~win;
                        bus.done1 <= win;
                        bus.rdata <= bus.ram_dout;
                    end else begin
                        wcnt <= wcnt - CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    last  <= win;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: dut_a uses RD_LAT=1, dut_b uses RD_LAT=3.
module tb_ram_arbiter;
    localparam int unsigned AW       = 3;
    localparam int unsigned DW       = 16;
    localparam int unsigned RD_LAT_A = 1;
    localparam int unsigned RD_LAT_B = 3;
    localparam int unsigned DEPTH    = 1 << AW;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    typedef struct {
        bit            port;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            gcyc;
        int            dcyc;
    } exp_t;

    logic clk;
    logic rst;

    ram_arbiter_if #(.AW(AW), .DW(DW)) bus_a ();
    ram_arbiter_if #(.AW(AW), .DW(DW)) bus_b ();

    ram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    ram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM for dut_a: read data valid within the ram_re cycle.
    logic [DW-1:0] mem_a [0:DEPTH-1];
    always_ff @(posedge clk) if (bus_a.ram_we) mem_a[bus_a.ram_waddr] <= bus_a.ram_din;
    assign bus_a.ram_dout = mem_a[bus_a.ram_raddr];

    // RAM for dut_b: read data delayed by RD_LAT_B-1 extra stages.
    logic [DW-1:0] mem_b  [0:DEPTH-1];
    logic [DW-1:0] pipe_b [0:RD_LAT_B-2];
    always_ff @(posedge clk) if (bus_b.ram_we) mem_b[bus_b.ram_waddr] <= bus_b.ram_din;
    always_ff @(posedge clk) begin
        pipe_b[0] <= mem_b[bus_b.ram_raddr];
        for (int i = 1; i < int'(RD_LAT_B) - 1; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign bus_b.ram_dout = pipe_b[RD_LAT_B-2];

    int            checks = 0;
    int            errors = 0;
    bit            m_last;
    logic [DW-1:0] last_rdata;
    logic [DW-1:0] golden [0:DEPTH-1];
    txn_t          tq0[$];
    txn_t          tq1[$];
    exp_t          sb[$];
    bit            gnt_hist[$];

    task automatic clear_inputs();
        bus_a.req0 = 1'b0; bus_a.req1 = 1'b0; bus_a.wr0 = 1'b0; bus_a.wr1 = 1'b0;
        bus_a.addr0 = '0; bus_a.addr1 = '0; bus_a.wdata0 = '0; bus_a.wdata1 = '0;
        bus_b.req0 = 1'b0; bus_b.req1 = 1'b0; bus_b.wr0 = 1'b0; bus_b.wr1 = 1'b0;
        bus_b.addr0 = '0; bus_b.addr1 = '0; bus_b.wdata0 = '0; bus_b.wdata1 = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1;
        last_rdata = '0;
        @(negedge clk);
    endtask

    task automatic present0();
        if (tq0.size() > 0) begin
            bus_a.req0 = 1'b1; bus_a.wr0 = tq0[0].wr;
            bus_a.addr0 = tq0[0].addr; bus_a.wdata0 = tq0[0].data;
        end else begin
            bus_a.req0 = 1'b0;
        end
    endtask

    task automatic present1();
        if (tq1.size() > 0) begin
            bus_a.req1 = 1'b1; bus_a.wr1 = tq1[0].wr;
            bus_a.addr1 = tq1[0].addr; bus_a.wdata1 = tq1[0].data;
        end else begin
            bus_a.req1 = 1'b0;
        end
    endtask

    // Predicts order/timing/data of the queued traffic on dut_a, then runs it.
    task automatic run_traffic();
        txn_t p0[$];
        txn_t p1[$];
        txn_t t;
        exp_t e;
        int   prev_done;
        int   cyc;
        int   limit;
        p0 = tq0; p1 = tq1; prev_done = -1;
        sb.delete(); gnt_hist.delete();
        while (p0.size() > 0 || p1.size() > 0) begin
            if (p0.size() > 0 && p1.size() > 0) e.port = ~m_last;
            else e.port = (p1.size() > 0);
            t = e.port ? p1.pop_front() : p0.pop_front();
            e.wr = t.wr; e.addr = t.addr;
            if (t.wr) begin
                golden[t.addr] = t.data;
                e.data = t.data;
            end else begin
                e.data = golden[t.addr];
            end
            e.gcyc = (prev_done < 0) ? 1 : prev_done + 2;
            e.dcyc = e.gcyc + (t.wr ? 1 : int'(RD_LAT_A));
            prev_done = e.dcyc;
            m_last = e.port;
            sb.push_back(e);
        end
        limit = prev_done + 10;
        present0(); present1();
        cyc = 0;
        while (sb.size() > 0 && cyc < limit) begin
            @(negedge clk);
            cyc++;
            checks++;
            if ((bus_a.ram_we & bus_a.ram_re) !== 1'b0) begin
                errors++; $display("FAIL we_re_exclusive: cycle %0d we %b re %b, required not both", cyc, bus_a.ram_we, bus_a.ram_re);
            end
            checks++;
            if ((bus_a.ram_we | bus_a.ram_re) !== (bus_a.gnt0 | bus_a.gnt1)) begin
                errors++; $display("FAIL enable_outside_access: cycle %0d we %b re %b gnt %b%b", cyc, bus_a.ram_we, bus_a.ram_re, bus_a.gnt1, bus_a.gnt0);
            end
            checks++;
            if ($countones({bus_a.gnt0, bus_a.gnt1, bus_a.done0, bus_a.done1}) > 1) begin
                errors++; $display("FAIL pulse_exclusive: cycle %0d gnt %b%b done %b%b, required at most one", cyc, bus_a.gnt1, bus_a.gnt0, bus_a.done1, bus_a.done0);
            end
            if (bus_a.gnt0 || bus_a.gnt1) begin
                gnt_hist.push_back(bus_a.gnt1);
                checks++;
                if (bus_a.gnt1 !== sb[0].port || cyc != sb[0].gcyc) begin
                    errors++; $display("FAIL grant: port %b cycle %0d, required port %b cycle %0d", bus_a.gnt1, cyc, sb[0].port, sb[0].gcyc);
                end
                checks++;
                if (sb[0].wr) begin
                    if ({bus_a.ram_we, bus_a.ram_re, bus_a.ram_waddr, bus_a.ram_din} !== {2'b10, sb[0].addr, sb[0].data}) begin
                        errors++; $display("FAIL ram_write: we %b re %b waddr %0d din %h, required 1 0 %0d %h", bus_a.ram_we, bus_a.ram_re, bus_a.ram_waddr, bus_a.ram_din, sb[0].addr, sb[0].data);
                    end
                end else begin
                    if ({bus_a.ram_we, bus_a.ram_re, bus_a.ram_raddr} !== {2'b01, sb[0].addr}) begin
                        errors++; $display("FAIL ram_read: we %b re %b raddr %0d, required 0 1 %0d", bus_a.ram_we, bus_a.ram_re, bus_a.ram_raddr, sb[0].addr);
                    end
                end
                // Requester fields change after grant; latched transaction must win.
                if (bus_a.gnt1) begin
                    bus_a.wr1 = ~bus_a.wr1; bus_a.addr1 = AW'($urandom); bus_a.wdata1 = DW'($urandom);
                end else begin
                    bus_a.wr0 = ~bus_a.wr0; bus_a.addr0 = AW'($urandom); bus_a.wdata0 = DW'($urandom);
                end
            end
            if (bus_a.done0 || bus_a.done1) begin
                e = sb.pop_front();
                checks++;
                if (bus_a.done1 !== e.port || cyc != e.dcyc) begin
                    errors++; $display("FAIL done: port %b cycle %0d, required port %b cycle %0d", bus_a.done1, cyc, e.port, e.dcyc);
                end
                checks++;
                if (!e.wr) begin
                    if (bus_a.rdata !== e.data) begin
                        errors++; $display("FAIL rdata: addr %0d got %h, required %h", e.addr, bus_a.rdata, e.data);
                    end
                    last_rdata = e.data;
                end else if (bus_a.rdata !== last_rdata) begin
                    errors++; $display("FAIL rdata_hold: got %h after write, required %h", bus_a.rdata, last_rdata);
                end
                if (bus_a.done1) begin
                    void'(tq1.pop_front()); present1();
                end else begin
                    void'(tq0.pop_front()); present0();
                end
            end
        end
        if (sb.size() > 0) begin
            checks++; errors++;
            $display("FAIL timeout: %0d transactions outstanding after %0d cycles, required 0", sb.size(), cyc);
            sb.delete();
        end
        tq0.delete(); tq1.delete();
        bus_a.req0 = 1'b0; bus_a.req1 = 1'b0;
        @(negedge clk);
    endtask

    // One transaction on dut_b; reports what it observed.
    task automatic lat3_txn(input bit port, input bit wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, output int gcyc, output int dcyc,
                            output bit dport, output logic [DW-1:0] rd);
        gcyc = -1; dcyc = -1; dport = 1'b0; rd = 'x;
        if (port) begin
            bus_b.req1 = 1'b1; bus_b.wr1 = wr; bus_b.addr1 = a; bus_b.wdata1 = d;
        end else begin
            bus_b.req0 = 1'b1; bus_b.wr0 = wr; bus_b.addr0 = a; bus_b.wdata0 = d;
        end
        for (int c = 1; c <= 20 && dcyc < 0; c++) begin
            @(negedge clk);
            if ((bus_b.gnt0 || bus_b.gnt1) && gcyc < 0) gcyc = c;
            if (bus_b.done0 || bus_b.done1) begin
                dcyc = c; dport = bus_b.done1; rd = bus_b.rdata;
                bus_b.req0 = 1'b0; bus_b.req1 = 1'b0;
            end
        end
        bus_b.req0 = 1'b0; bus_b.req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #1;
        checks++;
        if ({bus_a.gnt0, bus_a.gnt1, bus_a.done0, bus_a.done1, bus_a.ram_we, bus_a.ram_re} !== 6'b0) begin
            errors++; $display("FAIL reset_pulses: %b, required 000000", {bus_a.gnt0, bus_a.gnt1, bus_a.done0, bus_a.done1, bus_a.ram_we, bus_a.ram_re});
        end
        checks++;
        if (bus_a.rdata !== '0 || bus_a.ram_din !== '0) begin
            errors++; $display("FAIL reset_data: rdata %h din %h, required 0 0", bus_a.rdata, bus_a.ram_din);
        end
        checks++;
        if (bus_a.ram_waddr !== '0 || bus_a.ram_raddr !== '0) begin
            errors++; $display("FAIL reset_addr: waddr %0d raddr %0d, required 0 0", bus_a.ram_waddr, bus_a.ram_raddr);
        end
        checks++;
        if ({bus_b.gnt0, bus_b.gnt1, bus_b.done0, bus_b.done1, bus_b.ram_we, bus_b.ram_re} !== 6'b0) begin
            errors++; $display("FAIL reset_pulses_b: %b, required 000000", {bus_b.gnt0, bus_b.gnt1, bus_b.done0, bus_b.done1, bus_b.ram_we, bus_b.ram_re});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1;
        last_rdata = '0;
        @(negedge clk);
    endtask

    task automatic test_write_readback();
        tq0.push_back('{wr: 1'b1, addr: AW'(3), data: 16'hABCD});
        run_traffic();
        tq0.push_back('{wr: 1'b0, addr: AW'(3), data: 16'h0000});
        run_traffic();
    endtask

    task automatic test_simultaneous();
        apply_reset();
        tq0.push_back('{wr: 1'b1, addr: AW'(5), data: 16'h1234});
        tq1.push_back('{wr: 1'b1, addr: AW'(5), data: 16'h5678});
        run_traffic();
        checks++;
        if (gnt_hist.size() != 2 || gnt_hist[0] != 1'b0) begin
            errors++; $display("FAIL simultaneous_order: %0d grants, first port %b, required 2 grants first port 0", gnt_hist.size(), (gnt_hist.size() > 0) ? gnt_hist[0] : 1'b1);
        end
        tq0.push_back('{wr: 1'b0, addr: AW'(5), data: 16'h0000});
        run_traffic();
        checks++;
        if (bus_a.rdata !== 16'h5678) begin
            errors++; $display("FAIL simultaneous_final: rdata %h, required 5678", bus_a.rdata);
        end
    endtask

    task automatic test_fairness();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            tq0.push_back('{wr: 1'b0, addr: AW'(3), data: 16'h0000});
            tq1.push_back('{wr: 1'b0, addr: AW'(5), data: 16'h0000});
        end
        run_traffic();
        checks++;
        if (gnt_hist.size() != 8) begin
            errors++; $display("FAIL fairness_count: %0d grants, required 8", gnt_hist.size());
        end
        for (int i = 0; i < gnt_hist.size(); i++) begin
            checks++;
            if (gnt_hist[i] != 1'(i % 2)) begin
                errors++; $display("FAIL fairness_order: grant %0d port %b, required %b", i, gnt_hist[i], 1'(i % 2));
            end
        end
    endtask

    task automatic test_latency();
        int gc;
        int dc;
        bit dp;
        logic [DW-1:0] rd;
        lat3_txn(1'b0, 1'b1, AW'(2), 16'hBEEF, gc, dc, dp, rd);
        checks++;
        if (gc != 1 || dc != 2 || dp != 1'b0) begin
            errors++; $display("FAIL lat3_write: gnt %0d done %0d port %b, required 1 2 0", gc, dc, dp);
        end
        lat3_txn(1'b0, 1'b0, AW'(2), 16'h0000, gc, dc, dp, rd);
        checks++;
        if (gc != 1 || dc != 4 || rd !== 16'hBEEF) begin
            errors++; $display("FAIL lat3_read: gnt %0d done %0d rdata %h, required 1 4 beef", gc, dc, rd);
        end
        lat3_txn(1'b1, 1'b1, AW'(5), 16'hC0DE, gc, dc, dp, rd);
        checks++;
        if (gc != 1 || dc != 2 || dp != 1'b1) begin
            errors++; $display("FAIL lat3_write1: gnt %0d done %0d port %b, required 1 2 1", gc, dc, dp);
        end
    endtask

    task automatic test_reset_mid_read();
        int gc;
        int dc;
        bit dp;
        logic [DW-1:0] rd;
        bus_b.req0 = 1'b1; bus_b.wr0 = 1'b0; bus_b.addr0 = AW'(2);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus_b.req0 = 1'b0;
        #1;
        checks++;
        if ({bus_b.gnt0, bus_b.gnt1, bus_b.done0, bus_b.done1, bus_b.ram_we, bus_b.ram_re} !== 6'b0) begin
            errors++; $display("FAIL midreset_pulses: %b, required 000000", {bus_b.gnt0, bus_b.gnt1, bus_b.done0, bus_b.done1, bus_b.ram_we, bus_b.ram_re});
        end
        checks++;
        if (bus_b.rdata !== '0 || bus_b.ram_raddr !== '0 || bus_b.ram_waddr !== '0 || bus_b.ram_din !== '0) begin
            errors++; $display("FAIL midreset_data: rdata %h raddr %0d waddr %0d din %h, required all 0", bus_b.rdata, bus_b.ram_raddr, bus_b.ram_waddr, bus_b.ram_din);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) begin
                rst = 1'b0;
                m_last = 1'b1;
                last_rdata = '0;
            end
            checks++;
            if ((bus_b.done0 | bus_b.done1) !== 1'b0) begin
                errors++; $display("FAIL midreset_no_done: cycle %0d done %b%b, required 00", i, bus_b.done1, bus_b.done0);
            end
        end
        lat3_txn(1'b1, 1'b0, AW'(5), 16'h0000, gc, dc, dp, rd);
        checks++;
        if (gc != 1 || dc != 4 || dp != 1'b1 || rd !== 16'hC0DE) begin
            errors++; $display("FAIL midreset_recover: gnt %0d done %0d port %b rdata %h, required 1 4 1 c0de", gc, dc, dp, rd);
        end
    endtask

    task automatic test_random();
        txn_t t;
        for (int a = 0; a < int'(DEPTH); a++) begin
            tq0.push_back('{wr: 1'b1, addr: AW'(a), data: DW'($urandom)});
        end
        run_traffic();
        for (int i = 0; i < 1000; i++) begin
            t.wr = 1'($urandom_range(0, 1));
            t.addr = AW'($urandom);
            t.data = DW'($urandom);
            if ($urandom_range(0, 1) == 0) tq0.push_back(t);
            else tq1.push_back(t);
        end
        run_traffic();
    endtask

    initial begin
        rst = 1'b1;
        m_last = 1'b1;
        last_rdata = '0;
        clear_inputs();
        test_reset();
        test_write_readback();
        test_simultaneous();
        test_fairness();
        test_latency();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
